ws2812_frame_ctrl: RTL
======================

Name: ws2812_frame_ctrl

Overview:
Frame sequencer between the SLIP byte receiver and the WS2812 bit encoder. It stores receiver writes (addr/data/strobe) in an internal pixel byte buffer. On end-of-frame it streams the stored bytes, in address order, to the bit encoder over a valid/ready handshake. After the last byte it enforces the WS2812 latch gap before accepting the next frame.

Parameters:
ADDR_W, 8, buffer address width; depth = 2**ADDR_W bytes
LATCH_CYCLES, 2400, idle clocks after last byte (50 us at 48 MHz)
CNT_W, 12, latch counter width; must hold LATCH_CYCLES

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (reset==0 resets)
wr_addr  in  ADDR_W  buffer write address from receiver
wr_data  in  8  buffer write data
wr_strobe  in  1  one-cycle write enable
frame_end  in  1  one-cycle pulse: frame complete
frame_len  in  ADDR_W+1  byte count of completed frame, sampled with frame_end
tx_data  out  8  byte to bit encoder
tx_valid  out  1  tx_data valid
tx_ready  in  1  encoder accepts byte
busy  out  1  high while FETCH/SEND/LATCH
drop_count  out  8  saturating count of dropped writes/frames

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, tx_valid=0, tx_data=0, busy=0, drop_count=0, rd_ptr=0, latch counter=0. Buffer contents are not cleared. Reset mid-frame aborts the frame; tx_valid is 0 from the next edge.
- Buffer: synchronous write, synchronous read, 1-cycle read latency. A write at edge t is visible to a read issued at t+1.
- IDLE:
  - wr_strobe writes buffer[wr_addr]=wr_data.
  - frame_end with frame_len==0: ignored, stay IDLE, no drop count.
  - frame_end with frame_len>0: latch len=min(frame_len, 2**ADDR_W), rd_ptr=0, go to FETCH.
  - wr_strobe and frame_end in the same cycle: write is performed and included in the frame.
- FETCH (1 cycle): read buffer[rd_ptr], go to SEND. tx_valid=1 with the byte on entering SEND, i.e. 2 cycles after frame_end.
- SEND:
  - tx_data/tx_valid are held stable until tx_valid&&tx_ready.
  - On handshake with rd_ptr==len-1: tx_valid=0, counter=LATCH_CYCLES, go to LATCH.
  - On handshake otherwise: rd_ptr++, tx_valid=0, go to FETCH. One bubble cycle per byte is permitted.
- LATCH: counter decrements each cycle; when it reaches 0, go to IDLE. Total gap is LATCH_CYCLES cycles with tx_valid=0.
- busy = (state != IDLE), registered with the state.
- While busy (single-buffer build):
  - wr_strobe is dropped (buffer unchanged), drop_count++.
  - frame_end is dropped, drop_count++.
  - Both in the same cycle: +2.
  - drop_count saturates at 255.
- tx_ready while tx_valid==0 is ignored.

Optional Feature:
Macro WS2812_DOUBLE_BUFFER_EN.
- Defined:
  - Two banks; writes always go to the back bank and are never dropped.
  - frame_end in IDLE swaps banks and starts streaming from the new front bank.
  - frame_end while busy sets a one-deep pending flag and latches its len. A second frame_end while pending overwrites len and increments drop_count.
  - Writes after a pending frame_end modify the pending (back) bank.
  - On LATCH expiry with pending set: swap, clear pending, enter FETCH directly with no IDLE cycle.
- Undefined: single bank, drop behaviour exactly as above.

Test Plan:
- Write bytes 0x11,0x22,0x33 to addr 0..2, frame_end len=3, tx_ready=1 constantly -> tx_data 0x11,0x22,0x33 in order, tx_valid 2 cycles after frame_end, then exactly LATCH_CYCLES cycles idle, then busy=0.
- Same frame with tx_ready low for 5 cycles on byte 2 -> tx_data=0x22 and tx_valid held stable all 5 cycles, no byte skipped or duplicated.
- frame_end len=0 -> busy stays 0, tx_valid never asserts, drop_count=0.
- Single-buffer: 3 writes and 1 frame_end issued during SEND -> buffer unchanged afterwards, drop_count=4; 300 drops -> drop_count=255.
- Assert reset (0) during SEND of byte 1 of 4 -> next edge tx_valid=0, busy=0, drop_count=0; a new frame_end len=2 streams buffer[0..1] correctly.
- WS2812_DOUBLE_BUFFER_EN: frame A (0xAA x2) streaming; write 0xBB x2, frame_end len=2 during SEND -> A completes, LATCH_CYCLES gap, then 0xBB,0xBB with no IDLE cycle between, drop_count=0.

Source files
------------

// File: rtl/ws2812_frame_ctrl_if.sv
// ws2812_frame_ctrl_if: bus bundle between the SLIP receiver, the frame
// controller and the WS2812 bit encoder.
// Signals:
//   wr_addr/wr_data/wr_strobe  receiver byte writes into the pixel buffer
//   frame_end/frame_len        end-of-frame pulse and byte count
//   tx_data/tx_valid/tx_ready  byte stream handshake toward the encoder
// Modports: master = receiver/encoder side, slave = frame controller.
interface ws2812_frame_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_strobe;
    logic              frame_end;
    logic [ADDR_W:0]   frame_len;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output wr_addr, wr_data, wr_strobe,
        output frame_end, frame_len,
        output tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  wr_addr, wr_data, wr_strobe,
        input  frame_end, frame_len,
        input  tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl: buffers receiver pixel bytes, streams a completed frame
// to the WS2812 encoder in address order, then holds the latch gap.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   bus        ws2812_frame_ctrl_if.slave (writes, frame_end, tx stream)
//   busy       high while FETCH/SEND/LATCH
//   drop_count saturating count of dropped writes/frames
// Build option: WS2812_DOUBLE_BUFFER_EN selects the two-bank buffer with a
// one-deep pending frame; undefined gives a single bank that drops while busy.
module ws2812_frame_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int LATCH_CYCLES = 2400,
    parameter int CNT_W        = 12
) (
    input  logic                clk,
    input  logic                reset,
    ws2812_frame_ctrl_if.slave  bus,
    output logic                busy,
    output logic [7:0]          drop_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_LEN = (ADDR_W+1)'(1);
    localparam logic [CNT_W-1:0] LATCH_INIT = CNT_W'(LATCH_CYCLES);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

`ifdef WS2812_DOUBLE_BUFFER_EN
    localparam int BANK_W = 1;
`else
    localparam int BANK_W = 0;
`endif
    localparam int MEM_AW = ADDR_W + BANK_W;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        LATCH
    } state_t;

    state_t             state, state_n;
    logic [ADDR_W-1:0]  rd_ptr, rd_ptr_n;
    logic [ADDR_W:0]    len, len_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               tx_valid_n;
    logic [1:0]         drop_inc;
    logic [8:0]         drop_sum;
    logic [7:0]         drop_n;
    logic               wr_en;
    logic               last;
    logic               frame_go;
    logic [ADDR_W:0]    clamp_len;
    logic [MEM_AW-1:0]  wr_idx;
    logic [MEM_AW-1:0]  rd_idx;

    logic [7:0] mem [1 << MEM_AW];

`ifdef WS2812_DOUBLE_BUFFER_EN
    logic               front, front_n;
    logic               pend, pend_n;
    logic [ADDR_W:0]    pend_len, pend_len_n;

    // Receiver always fills the back bank; the encoder reads the front bank.
    assign wr_idx = {~front, bus.wr_addr};
    assign rd_idx = {front, rd_ptr};
`else
    assign wr_idx = bus.wr_addr;
    assign rd_idx = rd_ptr;
`endif

    assign clamp_len = (bus.frame_len > MAX_LEN) ? MAX_LEN : bus.frame_len;
    assign frame_go  = bus.frame_end && (bus.frame_len != '0);
    assign last      = ({1'b0, rd_ptr} == (len - ONE_LEN));

    assign drop_sum = {1'b0, drop_count} + {7'b0, drop_inc};
    assign drop_n   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    always_comb begin
        state_n    = state;
        rd_ptr_n   = rd_ptr;
        len_n      = len;
        cnt_n      = cnt;
        tx_valid_n = bus.tx_valid;
        drop_inc   = 2'd0;
`ifdef WS2812_DOUBLE_BUFFER_EN
        front_n    = front;
        pend_n     = pend;
        pend_len_n = pend_len;
        wr_en      = bus.wr_strobe;
`else
        wr_en      = bus.wr_strobe && (state == IDLE);
        if (state != IDLE) begin
            drop_inc = {1'b0, bus.wr_strobe} + {1'b0, bus.frame_end};
        end
`endif

        unique case (state)
            IDLE: begin
                if (frame_go) begin
                    len_n    = clamp_len;
                    rd_ptr_n = '0;
                    state_n  = FETCH;
`ifdef WS2812_DOUBLE_BUFFER_EN
                    front_n  = ~front;
`endif
                end
            end
            FETCH: begin
                tx_valid_n = 1'b1;
                state_n    = SEND;
            end
            SEND: begin
                if (bus.tx_valid && bus.tx_ready) begin
                    tx_valid_n = 1'b0;
                    if (last) begin
                        cnt_n   = LATCH_INIT;
                        state_n = LATCH;
                    end else begin
                        rd_ptr_n = rd_ptr + 1'b1;
                        state_n  = FETCH;
                    end
                end
            end
            LATCH: begin
                cnt_n = cnt - ONE_CNT;
                // Exit on the cycle the count would reach zero so the
                // gap is exactly LATCH_CYCLES clocks long.
                if (cnt <= ONE_CNT) begin
                    cnt_n   = '0;
                    state_n = IDLE;
`ifdef WS2812_DOUBLE_BUFFER_EN
                    if (pend) begin
                        front_n  = ~front;
                        pend_n   = 1'b0;
                        len_n    = pend_len;
                        rd_ptr_n = '0;
                        state_n  = FETCH;
                    end
`endif
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

`ifdef WS2812_DOUBLE_BUFFER_EN
        // pend_n reflects any consumption at latch expiry, so a frame_end
        // landing on that same cycle is queued without counting a drop.
        if ((state != IDLE) && frame_go) begin
            if (pend_n) begin
                drop_inc = 2'd1;
            end
            pend_n     = 1'b1;
            pend_len_n = clamp_len;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            len          <= '0;
            cnt          <= '0;
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= 8'h00;
            busy         <= 1'b0;
            drop_count   <= 8'h00;
`ifdef WS2812_DOUBLE_BUFFER_EN
            front        <= 1'b0;
            pend         <= 1'b0;
            pend_len     <= '0;
`endif
        end else begin
            state        <= state_n;
            rd_ptr       <= rd_ptr_n;
            len          <= len_n;
            cnt          <= cnt_n;
            bus.tx_valid <= tx_valid_n;
            busy         <= (state_n != IDLE);
            drop_count   <= drop_n;
            if (state == FETCH) begin
                bus.tx_data <= mem[rd_idx];
            end
`ifdef WS2812_DOUBLE_BUFFER_EN
            front        <= front_n;
            pend         <= pend_n;
            pend_len     <= pend_len_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= bus.wr_data;
        end
    end
endmodule
